cram_port_arbiter: RTL and testbench

- Shares the four CoMeFa RAM ports between three requesters:
  - execute stream from the instruction controller (broadcast write on port 1)
  - transposed-data loader from the DRAM-to-CRAM swizzle (single-RAM write on port 1)
  - CPU readback path (port 2)
- Sits between those requesters and the comefa instances.
- Replaces the ad-hoc execute/load muxing with a sequenced, starvation-free arbiter that keeps execute sequences atomic.

---
 rtl/cram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_cram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_port_arbiter.sv
// Shares the CoMeFa RAM ports between the execute stream, the transposed-data loader and CPU readback.
// Execute sequences are atomic; loads yield to a waiting execute after a bounded burst.
module cram_port_arbiter #(
    parameter int AWIDTH         = 9,
    parameter int DWIDTH         = 40,
    parameter int NUM_RAMS       = 4,
    parameter int RAMSEL_W       = 2,
    parameter int MAX_LOAD_BURST = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       exec_valid,
    input  logic [AWIDTH-1:0]          exec_addr,
    input  logic [DWIDTH-1:0]          exec_data,
    input  logic                       exec_last,
    output logic                       exec_ready,
    input  logic                       load_valid,
    input  logic [AWIDTH-1:0]          load_addr,
    input  logic [DWIDTH-1:0]          load_data,
    input  logic [RAMSEL_W-1:0]        load_ram_num,
    output logic                       load_ready,
    input  logic                       rd_valid,
    input  logic [AWIDTH-1:0]          rd_addr,
    input  logic [RAMSEL_W-1:0]        rd_ram_num,
    output logic                       rd_ready,
    output logic                       rd_data_valid,
    output logic [DWIDTH-1:0]          rd_data,
    output logic [AWIDTH-1:0]          cram_addr,
    output logic [DWIDTH-1:0]          cram_data,
    output logic [NUM_RAMS-1:0]        cram_we,
    output logic [AWIDTH-1:0]          cram_rd_addr,
    input  logic [NUM_RAMS*DWIDTH-1:0] cram_q,
    output logic                       busy
);
    localparam int CNT_W = (MAX_LOAD_BURST > 1) ? $clog2(MAX_LOAD_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOAD_BURST - 1);
    localparam logic OWN_LOAD = 1'b0;
    localparam logic OWN_EXEC = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_LOAD} state_t;

    state_t              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic [RAMSEL_W-1:0] rd_ram_q, rd_ram_d;
    logic                rd_data_valid_q, rd_data_valid_d;
    logic [DWIDTH-1:0]   rd_data_q, rd_data_d;

    logic [NUM_RAMS-1:0] load_we;
    logic [DWIDTH-1:0]   q_slice [NUM_RAMS];
    logic [DWIDTH-1:0]   rd_slice;
    logic                load_hazard;
    logic                rd_fire;

    // Out-of-range RAM numbers decode to no enable at all.
    for (genvar gi = 0; gi < NUM_RAMS; gi++) begin : g_ram
        assign load_we[gi] = (int'(load_ram_num) == gi);
        assign q_slice[gi] = cram_q[gi*DWIDTH +: DWIDTH];
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        load_cnt_d   = load_cnt_q;
        exec_ready   = 1'b0;
        load_ready   = 1'b0;
        cram_we      = '0;
        cram_addr    = exec_addr;
        cram_data    = exec_data;
        case (state_q)
            ST_IDLE: begin
                if (exec_valid && (last_owner_q == OWN_LOAD || !load_valid)) begin
                    state_d = ST_EXEC;
                end else if (load_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_EXEC: begin
                exec_ready = 1'b1;
                if (exec_valid) begin
                    cram_we = '1;
                    if (exec_last) begin
                        state_d      = ST_IDLE;
                        last_owner_d = OWN_EXEC;
                    end
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                cram_addr  = load_addr;
                cram_data  = load_data;
                if (load_valid) begin
                    cram_we = load_we;
                    // Counter saturates; it only forces a hand-over while an execute is waiting.
                    if (load_cnt_q == CNT_MAX && exec_valid) begin
                        state_d      = ST_IDLE;
                        last_owner_d = OWN_LOAD;
                        load_cnt_d   = '0;
                    end else if (load_cnt_q != CNT_MAX) begin
                        load_cnt_d = load_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d      = ST_IDLE;
                    last_owner_d = OWN_LOAD;
                    load_cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_RAMS; i++) begin
            if (int'(rd_ram_q) == i) begin
                rd_slice = q_slice[i];
            end
        end
    end

    assign load_hazard = (state_q == ST_LOAD) && load_valid &&
                         (load_ram_num == rd_ram_num) && (load_addr == rd_addr);
    assign rd_ready     = (state_q != ST_EXEC) && !load_hazard;
    assign rd_fire      = rd_valid && rd_ready;
    assign cram_rd_addr = rd_addr;

    always_comb begin
        rd_pend_d       = rd_fire;
        rd_ram_d        = rd_fire ? rd_ram_num : rd_ram_q;
        rd_data_valid_d = rd_pend_q;
        rd_data_d       = rd_pend_q ? rd_slice : rd_data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            last_owner_q    <= OWN_LOAD;
            load_cnt_q      <= '0;
            rd_pend_q       <= 1'b0;
            rd_ram_q        <= '0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            last_owner_q    <= last_owner_d;
            load_cnt_q      <= load_cnt_d;
            rd_pend_q       <= rd_pend_d;
            rd_ram_q        <= rd_ram_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    assign rd_data_valid = rd_data_valid_q;
    assign rd_data       = rd_data_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Table-driven bench for cram_port_arbiter plus hand-written burst-limit and async-reset sequences.
module tb_cram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 40;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          exec_valid, exec_last, exec_ready;
    logic [AW-1:0] exec_addr;
    logic [DW-1:0] exec_data;
    logic          load_valid, load_ready;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [1:0]    load_ram_num;
    logic          rd_valid, rd_ready, rd_data_valid;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_ram_num;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] cram_addr, cram_rd_addr;
    logic [DW-1:0] cram_data;
    logic [NR-1:0] cram_we;
    logic [NR*DW-1:0] cram_q;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cram_port_arbiter dut (
        .clk(clk), .resetn(resetn),
        .exec_valid(exec_valid), .exec_addr(exec_addr), .exec_data(exec_data),
        .exec_last(exec_last), .exec_ready(exec_ready),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ram_num(load_ram_num), .load_ready(load_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ram_num(rd_ram_num),
        .rd_ready(rd_ready), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .cram_addr(cram_addr), .cram_data(cram_data), .cram_we(cram_we),
        .cram_rd_addr(cram_rd_addr), .cram_q(cram_q), .busy(busy)
    );

    function automatic logic [DW-1:0] ram_word(input int r, input logic [AW-1:0] a);
        if (r == 1 && a == 9) return 40'hAB_CDEF0123;
        return {8'(8'hC0 + r), 23'd0, a};
    endfunction

    // Port-2 RAM model: data appears one cycle after the address.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) cram_q[i*DW +: DW] <= ram_word(i, cram_rd_addr);
    end

    typedef struct {
        logic          ev, el;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic [1:0]    lr;
        logic          rv;
        logic [AW-1:0] ra;
        logic [1:0]    rr;
        logic          x_er, x_lr, x_rr;
        logic [NR-1:0] x_we;
        logic          x_busy, x_dv;
        logic [DW-1:0] x_rd;
    } vec_t;

    function automatic vec_t mk(input int ev, input int el, input int ea, input longint ed,
                                input int lv, input int la, input longint ld, input int lr,
                                input int rv, input int ra, input int rr,
                                input int xer, input int xlr, input int xrr, input int xwe,
                                input int xbusy, input int xdv, input logic [DW-1:0] xrd);
        vec_t v;
        v.ev = 1'(ev); v.el = 1'(el); v.ea = AW'(ea); v.ed = DW'(ed);
        v.lv = 1'(lv); v.la = AW'(la); v.ld = DW'(ld); v.lr = 2'(lr);
        v.rv = 1'(rv); v.ra = AW'(ra); v.rr = 2'(rr);
        v.x_er = 1'(xer); v.x_lr = 1'(xlr); v.x_rr = 1'(xrr); v.x_we = NR'(xwe);
        v.x_busy = 1'(xbusy); v.x_dv = 1'(xdv); v.x_rd = xrd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exec_valid = 0; exec_last = 0; exec_addr = '0; exec_data = '0;
        load_valid = 0; load_addr = '0; load_data = '0; load_ram_num = '0;
        rd_valid = 0; rd_addr = '0; rd_ram_num = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        exec_valid = v.ev; exec_last = v.el; exec_addr = v.ea; exec_data = v.ed;
        load_valid = v.lv; load_addr = v.la; load_data = v.ld; load_ram_num = v.lr;
        rd_valid = v.rv; rd_addr = v.ra; rd_ram_num = v.rr;
        #3;
        chk($sformatf("v%0d exec_ready", idx), 64'(exec_ready), 64'(v.x_er));
        chk($sformatf("v%0d load_ready", idx), 64'(load_ready), 64'(v.x_lr));
        chk($sformatf("v%0d rd_ready", idx), 64'(rd_ready), 64'(v.x_rr));
        chk($sformatf("v%0d cram_we", idx), 64'(cram_we), 64'(v.x_we));
        chk($sformatf("v%0d busy", idx), 64'(busy), 64'(v.x_busy));
        chk($sformatf("v%0d rd_data_valid", idx), 64'(rd_data_valid), 64'(v.x_dv));
        if (v.x_we != 0) begin
            xa = (v.x_we == '1) ? v.ea : v.la;
            xd = (v.x_we == '1) ? v.ed : v.ld;
            chk($sformatf("v%0d cram_addr", idx), 64'(cram_addr), 64'(xa));
            chk($sformatf("v%0d cram_data", idx), 64'(cram_data), 64'(xd));
        end
        if (v.x_dv) chk($sformatf("v%0d rd_data", idx), 64'(rd_data), 64'(v.x_rd));
        if (v.rv && v.x_rr) chk($sformatf("v%0d cram_rd_addr", idx), 64'(cram_rd_addr), 64'(v.ra));
        step();
    endtask

    initial begin
        vec_t tbl[$];
        string exp_tr;
        byte   code;
        int    lb, eb;

        // execute 5 beats with a stall, reads blocked meanwhile, then a read of RAM 1 addr 9
        tbl.push_back(mk(1,0,3,'h11, 0,0,0,0, 0,0,0, 0,0,1,0,0,0,40'd0));
        tbl.push_back(mk(1,0,3,'h11, 0,0,0,0, 1,9,1, 1,0,0,15,1,0,40'd0));
        tbl.push_back(mk(1,0,4,'h12, 0,0,0,0, 1,9,1, 1,0,0,15,1,0,40'd0));
        tbl.push_back(mk(0,0,5,'h13, 0,0,0,0, 1,9,1, 1,0,0,0,1,0,40'd0));
        tbl.push_back(mk(1,0,5,'h13, 0,0,0,0, 1,9,1, 1,0,0,15,1,0,40'd0));
        tbl.push_back(mk(1,0,6,'h14, 0,0,0,0, 1,9,1, 1,0,0,15,1,0,40'd0));
        tbl.push_back(mk(1,1,7,'h15, 0,0,0,0, 1,9,1, 1,0,0,15,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0,    0,0,0,0, 1,9,1, 0,0,1,0,0,0,40'd0));
        tbl.push_back(mk(0,0,0,0,    0,0,0,0, 0,0,0, 0,0,1,0,0,0,40'd0));
        tbl.push_back(mk(0,0,0,0,    0,0,0,0, 0,0,0, 0,0,1,0,0,1,ram_word(1,9)));
        // 3-beat load to RAM 2
        tbl.push_back(mk(0,0,0,0, 1,0,'h200,2, 0,0,0, 0,0,1,0,0,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 1,0,'h200,2, 0,0,0, 0,1,1,4,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 1,1,'h201,2, 0,0,0, 0,1,1,4,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 1,2,'h202,2, 0,0,0, 0,1,1,4,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,     0,0,0, 0,1,1,0,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,     0,0,0, 0,0,1,0,0,0,40'd0));
        // read-during-write hazard on RAM 0 addr 5, neighbour addr 6 accepted
        tbl.push_back(mk(0,0,0,0, 1,5,'h500,0, 0,0,0, 0,0,1,0,0,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 1,5,'h500,0, 1,5,0, 0,1,0,1,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 1,5,'h501,0, 1,6,0, 0,1,1,1,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,     0,0,0, 0,1,1,0,1,0,40'd0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,     0,0,0, 0,0,1,0,0,1,ram_word(0,6)));

        idle_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset cram_we", 64'(cram_we), 64'd0);
        chk("reset rd_data_valid", 64'(rd_data_valid), 64'd0);
        chk("reset rd_data", 64'(rd_data), 64'd0);
        chk("reset exec_ready", 64'(exec_ready), 64'd0);
        chk("reset load_ready", 64'(load_ready), 64'd0);
        resetn = 1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // load burst limit and alternation: I, 8 loads, I, 3 exec beats, I, load resumes
        exp_tr = "ILLLLLLLLIEEEIL";
        lb = 0;
        eb = 0;
        for (int c = 0; c < exp_tr.len(); c++) begin
            load_valid = 1; load_ram_num = 3; load_addr = AW'(lb); load_data = DW'(40'h300 + lb);
            exec_valid = (lb >= 1); exec_addr = AW'(20 + eb); exec_data = DW'(40'h700 + eb);
            exec_last = (eb == 2);
            rd_valid = 0;
            #3;
            if (exec_ready && cram_we == 4'b1111 && cram_addr == exec_addr) code = "E";
            else if (load_ready && cram_we == 4'b1000 && cram_addr == load_addr) code = "L";
            else if (!busy && cram_we == 4'b0000) code = "I";
            else code = "?";
            chk($sformatf("burst cycle %0d", c), 64'(code), 64'(exp_tr[c]));
            if (code == "L") lb++;
            if (code == "E") eb++;
            step();
        end
        idle_inputs();
        step();
        step();

        // asynchronous reset in the middle of execute beat 3
        exec_valid = 1; exec_addr = 40; exec_data = 'h41; rd_valid = 1; rd_addr = 7; rd_ram_num = 2;
        #3;
        chk("rst seq idle exec_ready", 64'(exec_ready), 64'd0);
        chk("rst seq idle rd_ready", 64'(rd_ready), 64'd1);
        step();
        rd_valid = 0; exec_addr = 41; exec_data = 'h42;
        #3;
        chk("rst seq beat1 cram_we", 64'(cram_we), 64'hF);
        step();
        exec_addr = 42; exec_data = 'h43;
        #3;
        chk("rst seq rd_data_valid", 64'(rd_data_valid), 64'd1);
        chk("rst seq rd_data", 64'(rd_data), 64'(ram_word(2, 7)));
        step();
        exec_addr = 43; exec_data = 'h44;
        #2;
        chk("rst seq beat3 cram_we", 64'(cram_we), 64'hF);
        #1 resetn = 0;
        #1;
        chk("async rst cram_we", 64'(cram_we), 64'd0);
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst exec_ready", 64'(exec_ready), 64'd0);
        chk("async rst rd_data_valid", 64'(rd_data_valid), 64'd0);
        chk("async rst rd_data", 64'(rd_data), 64'd0);
        step();
        resetn = 1;
        exec_valid = 1; exec_last = 0; exec_addr = 50; exec_data = 'h51;
        load_valid = 1; load_addr = 3; load_data = 'h33; load_ram_num = 1;
        #3;
        chk("post rst idle busy", 64'(busy), 64'd0);
        chk("post rst idle exec_ready", 64'(exec_ready), 64'd0);
        step();
        #3;
        chk("post rst exec wins", 64'(exec_ready), 64'd1);
        chk("post rst beat1 cram_we", 64'(cram_we), 64'hF);
        step();
        exec_last = 1; exec_addr = 51; exec_data = 'h52;
        #3;
        chk("post rst beat2 cram_addr", 64'(cram_addr), 64'd51);
        chk("post rst beat2 cram_data", 64'(cram_data), 64'h52);
        step();
        exec_valid = 0; exec_last = 0;
        #3;
        chk("post rst bubble busy", 64'(busy), 64'd0);
        step();
        #3;
        chk("post rst load turn", 64'(load_ready), 64'd1);
        chk("post rst load cram_we", 64'(cram_we), 64'b0010);
        step();
        idle_inputs();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
